// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath blocks.
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        SUB_IDLE  = 2'd0,
        SUB_SHIFT = 2'd1,
        SUB_DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - borrow_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell plus borrow flop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter  int WIDTH = ARITH_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy
);

    sub_state_e       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bw_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             last_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             bit_d;
    logic             bw_d;

    full_subtractor u_fs (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .borrow_in (bw_q),
        .diff      (bit_d),
        .borrow_out(bw_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SUB_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            bw_q      <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            last_q    <= 1'b0;
            borrow_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                SUB_IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        bw_q    <= borrow_in;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                        state_q <= SUB_SHIFT;
                    end
                end
                SUB_SHIFT: begin
                    if (!last_q) begin
                        a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
                        b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
                        diff_sh_q <= {bit_d, diff_sh_q[WIDTH-1:1]};
                        bw_q      <= bw_d;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1))
                            last_q <= 1'b1;
                    end else begin
                        // Transition edge: publish the completed result.
                        diff_q   <= diff_sh_q;
                        borrow_q <= bw_q;
                        ovf_q    <= (a_msb_q != b_msb_q) &&
                                    (diff_sh_q[WIDTH-1] != a_msb_q);
                        last_q   <= 1'b0;
                        state_q  <= SUB_DONE;
                    end
                end
                SUB_DONE: begin
                    if (out_ready)
                        state_q <= SUB_IDLE;
                end
                default: state_q <= SUB_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == SUB_IDLE) && !reset;
    assign out_valid  = (state_q == SUB_DONE);
    assign busy       = (state_q != SUB_IDLE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W      = 4;
    localparam int LAT    = W + 1;
    localparam int PERIOD = LAT + 2;
    localparam int NOPS   = 1000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic c);
        res_t r;
        int   full;
        int   sx;
        int   sy;
        int   s;
        full = int'(x) - int'(y) - int'(c);
        sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
        s    = sx - sy - int'(c);
        r.d  = W'(full & ((1 << W) - 1));
        r.bo = (full < 0);
        r.ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        a         = x;
        b         = y;
        borrow_in = c;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '1;
        b         = '1;
        borrow_in = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_valid, busy, borrow_out, overflow} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000",
                     {out_valid, busy, borrow_out, overflow});
            n_fail++;
        end
        n_checks++;
        if (diff !== '0) begin
            $display("FAIL reset_diff: got %0d expected 0", diff);
            n_fail++;
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
            n_fail++;
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
            n_fail++;
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vc [4];
        res_t         ve [4];
        int           lat;
        va = '{4'd7, 4'd3, 4'd0, 4'd8};
        vb = '{4'd3, 4'd7, 4'd0, 4'd1};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        ve = '{'{4'd4, 1'b0, 1'b0}, '{4'hC, 1'b1, 1'b0},
               '{4'hF, 1'b1, 1'b0}, '{4'd7, 1'b0, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vc[i]);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL dir%0d_busy: got busy=%b in_ready=%b expected 1/0",
                         i, busy, in_ready);
                n_fail++;
            end
            wait_done(lat);
            n_checks++;
            if (lat != LAT) begin
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT);
                n_fail++;
            end
            n_checks++;
            if ({diff, borrow_out, overflow} !== ve[i]) begin
                $display("FAIL dir%0d_result: got %h/%b/%b expected %h/%b/%b",
                         i, diff, borrow_out, overflow, ve[i].d, ve[i].bo, ve[i].ov);
                n_fail++;
            end
            n_checks++;
            if (ve[i] !== model(va[i], vb[i], vc[i])) begin
                $display("FAIL dir%0d_model: got %h expected %h",
                         i, model(va[i], vb[i], vc[i]), ve[i]);
                n_fail++;
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL dir%0d_consume: got out_valid=%b in_ready=%b expected 0/1",
                         i, out_valid, in_ready);
                n_fail++;
            end
        end
    endtask

    task automatic test_backpressure();
        res_t exp_r;
        int   lat;
        exp_r = model(4'd9, 4'd4, 1'b0);
        start_op(4'd9, 4'd4, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            borrow_in = 1'($urandom);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {diff, borrow_out, overflow} !== exp_r) begin
                $display("FAIL bp_hold%0d: got v=%b r=%b %h/%b/%b expected 1/0 %h/%b/%b",
                         i, out_valid, in_ready, diff, borrow_out, overflow,
                         exp_r.d, exp_r.bo, exp_r.ov);
                n_fail++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL bp_release: got v=%b r=%b busy=%b expected 0/1/0",
                     out_valid, in_ready, busy);
            n_fail++;
        end
        n_checks++;
        if ({diff, borrow_out, overflow} !== exp_r) begin
            $display("FAIL bp_result_kept: got %h/%b/%b expected %h/%b/%b",
                     diff, borrow_out, overflow, exp_r.d, exp_r.bo, exp_r.ov);
            n_fail++;
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        start_op(4'd12, 4'd5, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
            diff !== '0) begin
            $display("FAIL abort_state: got v=%b busy=%b r=%b diff=%0d expected 0/0/1/0",
                     out_valid, busy, in_ready, diff);
            n_fail++;
        end
        start_op(4'd5, 4'd2, 1'b0);
        wait_done(lat);
        n_checks++;
        if (diff !== 4'd3 || borrow_out !== 1'b0 || lat != LAT) begin
            $display("FAIL abort_next_op: got diff=%0d bo=%b lat=%0d expected 3/0/%0d",
                     diff, borrow_out, lat, LAT);
            n_fail++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e;
        bit   acc;
        int   done;
        int   cyc;
        int   last_acc;
        done      = 0;
        cyc       = 0;
        last_acc  = -1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
        while (done < NOPS && cyc < 20000) begin
            acc = in_ready && in_valid;
            if (acc)
                q.push_back(model(a, b, borrow_in));
            @(posedge clk);
            cyc++;
            if (acc) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != PERIOD) begin
                        $display("FAIL b2b_spacing: got %0d expected %0d",
                                 cyc - last_acc, PERIOD);
                        n_fail++;
                    end
                end
                last_acc = cyc;
            end
            #1;
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_spurious: got result with 0 pending expected none");
                    n_fail++;
                end else begin
                    e = q.pop_front();
                    if ({diff, borrow_out, overflow} !== e) begin
                        $display("FAIL b2b_result%0d: got %h/%b/%b expected %h/%b/%b",
                                 done, diff, borrow_out, overflow, e.d, e.bo, e.ov);
                        n_fail++;
                    end
                end
                done++;
            end
            a         = W'($urandom);
            b         = W'($urandom);
            borrow_in = 1'($urandom);
        end
        n_checks++;
        if (done != NOPS) begin
            $display("FAIL b2b_timeout: got %0d ops expected %0d", done, NOPS);
            n_fail++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
